visaccum_seq: RTL and testbench
===============================

Name: visaccum_seq

Overview:
- Sequencer for the periodic partial-sum accumulator. Drives its frame/valid strobes in lock-step with the fixed PSUMS×COUNT slot schedule and gates the upstream correlator partial-sum stream.
- Monitors the accumulator output stream and checks that every block delivers exactly PSUMS beats. Reports completion, underruns and sequencing errors to the control/status registers.

Parameters:
- PSUMS, 3, partial-sum slots per pass; must match the accumulator.
- COUNT, 5, passes per accumulation block; must match the accumulator.
- NBITS, 8, width of the block-count request and the status counters.
- DRAIN_MAX, 64, maximum cycles in DRAIN before a timeout error.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin a run; sampled in IDLE only
- abort_i  in  1  stop at the next block boundary
- blocks_i  in  NBITS  accumulation blocks to run; 0 means none, run completes immediately
- src_valid_i  in  1  upstream partial-sum beat available
- src_ready_o  out  1  beat consumed this cycle
- acc_frame_o  out  1  accumulator frame strobe
- acc_valid_o  out  1  accumulator valid strobe
- acc_frame_i  in  1  accumulator output frame
- acc_valid_i  in  1  accumulator output valid
- acc_last_i  in  1  accumulator output last
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- underrun_o  out  1  sticky: a RUN slot lacked source data
- seq_err_o  out  1  sticky: output beat-count mismatch or drain timeout
- blocks_out_o  out  NBITS  blocks received from the accumulator in this run

Behaviour:
- Reset: state=IDLE; every output 0; all counters 0. Reset mid-run aborts immediately, with no drain.
- Counters (RUN only):
  - slot 0..PSUMS-1, wraps each cycle;
  - pass 0..COUNT-1, advances on slot wrap;
  - blk 0..blocks_i-1, advances on pass wrap with slot wrap.
- IDLE:
  - start_i=1 with blocks_i≠0: latch blocks_i; clear underrun_o, seq_err_o, blocks_out_o; go to RUN next cycle.
  - start_i=1 with blocks_i=0: done_o=1 next cycle; stay IDLE.
- RUN:
  - acc_frame_o=1 on every RUN cycle; src_ready_o=1.
  - acc_valid_o=src_valid_i.
  - src_valid_i=0 sets underrun_o; the slot position still advances because the schedule is periodic.
  - Run length is exactly blocks×COUNT×PSUMS cycles.
  - Exit to DRAIN on the cycle after the final slot of the final block, or of the current block if abort_i has been seen (abort_i is latched sticky during RUN).
  - acc_frame_o falls on the same cycle as the transition.
- DRAIN:
  - acc_frame_o=0, src_ready_o=0.
  - Exit to DONE when blocks_out == blocks issued (completed blocks including the current one) and acc_frame_i=0.
  - Timeout counter reaching DRAIN_MAX sets seq_err_o and forces DONE.
- DONE: done_o=1 for one cycle; busy_o=0; next state IDLE.
- busy_o=1 in RUN and DRAIN.
- Output monitor (active in RUN and DRAIN):
  - beat counter increments on acc_valid_i.
  - On acc_valid_i & acc_last_i: if beats ≠ PSUMS (including the current beat), set seq_err_o; increment blocks_out_o (saturating at 2^NBITS-1); clear beat counter.
  - acc_valid_i seen in IDLE sets seq_err_o.
- Simultaneous events:
  - abort_i on the final slot of the final block: normal completion.
  - start_i outside IDLE: ignored.
  - acc_last_i on the same cycle as the timeout: the count is applied first, then the timeout is evaluated.

Test Plan:
- PSUMS=3, COUNT=5, blocks_i=2, src_valid_i=1 throughout:
  - acc_frame_o high exactly 30 cycles; acc_valid_o high for 30 cycles.
  - A bench model of the accumulator returns 2 blocks of 3 beats each → blocks_out_o=2; done_o pulses once; underrun_o=0; seq_err_o=0.
- Same setup, src_valid_i=0 for slot 4 only: acc_valid_o low that cycle; underrun_o=1; run length is still 30 cycles; done_o asserts.
- blocks_i=4 with abort_i pulsed at cycle 20 (block 1): RUN stops after 30 cycles; blocks_out_o=2; done_o pulses.
- Model emits only 2 beats before acc_last_i → seq_err_o=1; blocks_out_o still increments.
- Model never returns data → DRAIN times out after 64 cycles; seq_err_o=1; done_o pulses.
- reset asserted at RUN cycle 7: next cycle busy_o=0, acc_frame_o=0, all flags 0. start_i with blocks_i=0 → done_o pulse with no RUN cycles.

Source files
------------

// File: rtl/visaccum_seq.sv
// visaccum_seq: sequencer for the periodic partial-sum accumulator.
//
// Walks a fixed slot schedule of PSUMS slots per pass, COUNT passes per block and the requested
// number of blocks. It strobes the accumulator frame/valid inputs in lock-step with that schedule
// and gates the upstream partial-sum stream. It also monitors the accumulator output stream: every
// block must deliver exactly PSUMS beats. Completion, underruns and sequencing errors are reported.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   start_i           begin a run (sampled in IDLE only)
//   abort_i           stop at the next block boundary
//   blocks_i          number of accumulation blocks to run (0 = complete immediately)
//   src_valid_i       upstream partial-sum beat available
//   src_ready_o       upstream beat consumed this cycle
//   acc_frame_o       accumulator frame strobe
//   acc_valid_o       accumulator valid strobe
//   acc_frame_i       accumulator output frame
//   acc_valid_i       accumulator output valid
//   acc_last_i        accumulator output last
//   busy_o            run in progress (RUN or DRAIN)
//   done_o            one-cycle completion pulse
//   underrun_o        sticky: a RUN slot lacked source data
//   seq_err_o         sticky: output beat-count mismatch, stray beat or drain timeout
//   blocks_out_o      blocks received from the accumulator in this run
module visaccum_seq #(
  parameter int unsigned PSUMS     = 3,
  parameter int unsigned COUNT     = 5,
  parameter int unsigned NBITS     = 8,
  parameter int unsigned DRAIN_MAX = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [NBITS-1:0] blocks_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  output logic             acc_frame_o,
  output logic             acc_valid_o,
  input  logic             acc_frame_i,
  input  logic             acc_valid_i,
  input  logic             acc_last_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic             seq_err_o,
  output logic [NBITS-1:0] blocks_out_o
);

  localparam int unsigned SlotW  = (PSUMS > 1) ? $clog2(PSUMS) : 1;
  localparam int unsigned PassW  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned DrainW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [PassW-1:0]  pass_q, pass_d;
  logic [NBITS-1:0]  blk_q, blk_d;
  logic [NBITS-1:0]  blocks_q, blocks_d;
  logic [NBITS-1:0]  issued_q, issued_d;
  logic              abort_q, abort_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [NBITS-1:0]  beat_q, beat_d;
  logic [NBITS-1:0]  blocks_out_q, blocks_out_d;
  logic              underrun_q, underrun_d;
  logic              seq_err_q, seq_err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              frame_q, frame_d;

  logic slot_last, pass_last, blk_last, stop_here;

  always_comb begin
    slot_last = (slot_q == SlotW'(PSUMS - 1));
    pass_last = (pass_q == PassW'(COUNT - 1));
    blk_last  = (blk_q == blocks_q - NBITS'(1));
    // Leave RUN after the last slot of the final block, or of the current block once aborted.
    stop_here = slot_last & pass_last & (blk_last | abort_q | abort_i);
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    pass_d       = pass_q;
    blk_d        = blk_q;
    blocks_d     = blocks_q;
    issued_d     = issued_q;
    abort_d      = abort_q;
    drain_d      = drain_q;
    beat_d       = beat_q;
    blocks_out_d = blocks_out_q;
    underrun_d   = underrun_q;
    seq_err_d    = seq_err_q;
    done_d       = 1'b0;

    // Output monitor. Evaluated before the FSM so the DRAIN exit sees a block that completes
    // on this very cycle, which also gives the count priority over a coincident timeout.
    if ((state_q == StRun || state_q == StDrain) && acc_valid_i) begin
      if (acc_last_i) begin
        if ((32'(beat_q) + 32'd1) != PSUMS) begin
          seq_err_d = 1'b1;
        end
        beat_d = '0;
        if (blocks_out_q != {NBITS{1'b1}}) begin
          blocks_out_d = blocks_out_q + NBITS'(1);
        end
      end else if (beat_q != {NBITS{1'b1}}) begin
        beat_d = beat_q + NBITS'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (acc_valid_i) begin
          seq_err_d = 1'b1;
        end
        if (start_i) begin
          if (blocks_i != '0) begin
            blocks_d     = blocks_i;
            underrun_d   = 1'b0;
            seq_err_d    = acc_valid_i;
            blocks_out_d = '0;
            beat_d       = '0;
            slot_d       = '0;
            pass_d       = '0;
            blk_d        = '0;
            abort_d      = 1'b0;
            state_d      = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!src_valid_i) begin
          underrun_d = 1'b1;
        end
        if (abort_i) begin
          abort_d = 1'b1;
        end
        // The schedule is periodic: slots advance whether or not source data arrived.
        if (slot_last) begin
          slot_d = '0;
          if (pass_last) begin
            pass_d = '0;
            blk_d  = blk_q + NBITS'(1);
          end else begin
            pass_d = pass_q + PassW'(1);
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
        if (stop_here) begin
          issued_d = blk_q + NBITS'(1);
          drain_d  = '0;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (blocks_out_d == issued_q && !acc_frame_i) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if ((32'(drain_q) + 32'd1) >= DRAIN_MAX) begin
          seq_err_d = 1'b1;
          state_d   = StDone;
          done_d    = 1'b1;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d  = (state_d == StRun) || (state_d == StDrain);
    frame_d = (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      pass_q       <= '0;
      blk_q        <= '0;
      blocks_q     <= '0;
      issued_q     <= '0;
      abort_q      <= 1'b0;
      drain_q      <= '0;
      beat_q       <= '0;
      blocks_out_q <= '0;
      underrun_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pass_q       <= pass_d;
      blk_q        <= blk_d;
      blocks_q     <= blocks_d;
      issued_q     <= issued_d;
      abort_q      <= abort_d;
      drain_q      <= drain_d;
      beat_q       <= beat_d;
      blocks_out_q <= blocks_out_d;
      underrun_q   <= underrun_d;
      seq_err_q    <= seq_err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      frame_q      <= frame_d;
    end
  end

  assign src_ready_o  = frame_q;
  assign acc_frame_o  = frame_q;
  // Valid follows the source directly so a missing beat blanks its slot.
  assign acc_valid_o  = frame_q & src_valid_i;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;
  assign seq_err_o    = seq_err_q;
  assign blocks_out_o = blocks_out_q;

endmodule

// File: tb/tb_visaccum_seq.sv
module tb_visaccum_seq;

  logic       clock;
  logic       reset;
  logic       start_i;
  logic       abort_i;
  logic [7:0] blocks_i;
  logic       src_valid_i;
  logic       src_ready_o;
  logic       acc_frame_o;
  logic       acc_valid_o;
  logic       acc_frame_i;
  logic       acc_valid_i;
  logic       acc_last_i;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;
  logic       seq_err_o;
  logic [7:0] blocks_out_o;

  int total;
  int bad;

  // Accumulator model and activity counters.
  int model_beats;
  int frame_cnt;
  int pend;
  int frame_hi;
  int valid_hi;
  int busy_hi;
  int done_cnt;

  visaccum_seq #(
    .PSUMS    (3),
    .COUNT    (5),
    .NBITS    (8),
    .DRAIN_MAX(64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .blocks_i    (blocks_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .acc_frame_o (acc_frame_o),
    .acc_valid_o (acc_valid_o),
    .acc_frame_i (acc_frame_i),
    .acc_valid_i (acc_valid_i),
    .acc_last_i  (acc_last_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .underrun_o  (underrun_o),
    .seq_err_o   (seq_err_o),
    .blocks_out_o(blocks_out_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // After every 15th frame cycle (one block) the model emits model_beats output beats.
  always @(negedge clock) begin
    acc_valid_i = 1'b0;
    acc_last_i  = 1'b0;
    acc_frame_i = 1'b0;
    if (reset) begin
      frame_cnt = 0;
      pend      = 0;
    end else begin
      if (pend > 0) begin
        acc_valid_i = 1'b1;
        acc_frame_i = 1'b1;
        pend        = pend - 1;
        if (pend == 0) acc_last_i = 1'b1;
      end
      if (acc_frame_o) begin
        frame_cnt = frame_cnt + 1;
        if (frame_cnt % 15 == 0) pend = model_beats;
      end
    end
    if (acc_frame_o) frame_hi = frame_hi + 1;
    if (acc_valid_o) valid_hi = valid_hi + 1;
    if (busy_o) busy_hi = busy_hi + 1;
    if (done_o) done_cnt = done_cnt + 1;
  end

  task automatic clear_counts();
    frame_hi = 0;
    valid_hi = 0;
    busy_hi  = 0;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    blocks_i    = 8'd0;
    src_valid_i = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic launch(input logic [7:0] nblk);
    start_i  = 1'b1;
    blocks_i = nblk;
    @(posedge clock);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    total++; if (acc_frame_o !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", acc_frame_o); end
    total++; if (src_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", src_ready_o); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun_o); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%b want=0", seq_err_o); end
    total++; if (blocks_out_o !== 8'd0) begin bad++; $display("FAIL reset_blocks_out got=%0d want=0", blocks_out_o); end
  endtask

  task automatic test_normal();
    bit ok;
    do_reset();
    model_beats = 3;
    launch(8'd2);
    total++; if (acc_frame_o !== 1'b1 || src_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL normal_run_entry got=%b%b%b want=111", acc_frame_o, src_ready_o, busy_o);
    end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL normal_done_seen got=0 want=1"); end
    repeat (3) @(posedge clock);
    #1;
    total++; if (frame_hi != 30) begin bad++; $display("FAIL normal_frame_cycles got=%0d want=30", frame_hi); end
    total++; if (valid_hi != 30) begin bad++; $display("FAIL normal_valid_cycles got=%0d want=30", valid_hi); end
    total++; if (blocks_out_o !== 8'd2) begin bad++; $display("FAIL normal_blocks_out got=%0d want=2", blocks_out_o); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL normal_done_pulses got=%0d want=1", done_cnt); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL normal_underrun got=%b want=0", underrun_o); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL normal_seq_err got=%b want=0", seq_err_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL normal_busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_underrun();
    bit ok;
    do_reset();
    model_beats = 3;
    launch(8'd2);
    repeat (4) @(posedge clock);
    #1;
    src_valid_i = 1'b0;
    #1;
    total++; if (acc_valid_o !== 1'b0 || acc_frame_o !== 1'b1) begin
      bad++; $display("FAIL under_slot4 got=valid%b frame%b want=valid0 frame1", acc_valid_o, acc_frame_o);
    end
    @(posedge clock);
    #1;
    src_valid_i = 1'b1;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL under_done_seen got=0 want=1"); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (frame_hi != 30) begin bad++; $display("FAIL under_frame_cycles got=%0d want=30", frame_hi); end
    total++; if (valid_hi != 29) begin bad++; $display("FAIL under_valid_cycles got=%0d want=29", valid_hi); end
    total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL under_flag got=%b want=1", underrun_o); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL under_seq_err got=%b want=0", seq_err_o); end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    model_beats = 3;
    launch(8'd4);
    repeat (20) @(posedge clock);
    #1;
    abort_i = 1'b1;
    @(posedge clock);
    #1;
    abort_i = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_done_seen got=0 want=1"); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (frame_hi != 30) begin bad++; $display("FAIL abort_frame_cycles got=%0d want=30", frame_hi); end
    total++; if (blocks_out_o !== 8'd2) begin bad++; $display("FAIL abort_blocks_out got=%0d want=2", blocks_out_o); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_done_pulses got=%0d want=1", done_cnt); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL abort_seq_err got=%b want=0", seq_err_o); end
  endtask

  task automatic test_short_block();
    bit ok;
    do_reset();
    model_beats = 2;
    launch(8'd2);
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL short_done_seen got=0 want=1"); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL short_seq_err got=%b want=1", seq_err_o); end
    total++; if (blocks_out_o !== 8'd2) begin bad++; $display("FAIL short_blocks_out got=%0d want=2", blocks_out_o); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    model_beats = 0;
    launch(8'd1);
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_done_seen got=0 want=1"); end
    repeat (2) @(posedge clock);
    #1;
    // 15 RUN cycles plus 64 DRAIN cycles before the forced DONE.
    total++; if (busy_hi != 79) begin bad++; $display("FAIL timeout_busy_cycles got=%0d want=79", busy_hi); end
    total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL timeout_seq_err got=%b want=1", seq_err_o); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL timeout_done_pulses got=%0d want=1", done_cnt); end
    total++; if (blocks_out_o !== 8'd0) begin bad++; $display("FAIL timeout_blocks_out got=%0d want=0", blocks_out_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    model_beats = 3;
    src_valid_i = 1'b0;
    launch(8'd2);
    repeat (7) @(posedge clock);
    #1;
    total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL midrst_pre_underrun got=%b want=1", underrun_o); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset       = 1'b0;
    src_valid_i = 1'b1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
    total++; if (acc_frame_o !== 1'b0) begin bad++; $display("FAIL midrst_frame got=%b want=0", acc_frame_o); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL midrst_underrun got=%b want=0", underrun_o); end
    total++; if (seq_err_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL midrst_flags got=err%b done%b want=err0 done0", seq_err_o, done_o);
    end
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_no_drain got=%b want=0", busy_o); end
  endtask

  task automatic test_zero_blocks();
    do_reset();
    launch(8'd0);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done_o); end
    total++; if (busy_o !== 1'b0 || acc_frame_o !== 1'b0) begin
      bad++; $display("FAIL zero_no_run got=busy%b frame%b want=busy0 frame0", busy_o, acc_frame_o);
    end
    @(posedge clock);
    #1;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done_o); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (frame_hi != 0) begin bad++; $display("FAIL zero_frame_cycles got=%0d want=0", frame_hi); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    model_beats = 3;
    frame_cnt   = 0;
    pend        = 0;
    clear_counts();
    test_reset();
    test_normal();
    test_underrun();
    test_abort();
    test_short_block();
    test_timeout();
    test_mid_reset();
    test_zero_blocks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
